// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if
// Control bundle between the multicycle MIPS main controller and its datapath.
//   master : the controller. It receives op, jumpreg, zero and mem_ready, and
//            drives every strobe, mux select and status pulse.
//   slave  : the datapath/memory side, with the same signals in the opposite
//            direction.
// Signals:
//   op[5:0]        instruction[31:26] from the instruction register
//   jumpreg        ALU decoder flag, funct == jr
//   zero           ALU zero flag (beq only)
//   mem_ready      memory completes the current read/write this cycle
//   memread/memwrite/iord/irwrite                memory and IR control
//   regwrite/regdst/memtoreg                     register file write control
//   alusrca/alusrcb[1:0]/zeroext/aluop[3:0]      ALU operand and op select
//   pcsrc[1:0]/pcwrite/pcwrite_en                next-PC select and enables
//   instr_done/illegal_op                        per-instruction status pulses
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic       jumpreg;
    logic       zero;
    logic       mem_ready;

    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [3:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       pcwrite_en;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  op, jumpreg, zero, mem_ready,
        output memread, memwrite, iord, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, zeroext, aluop, pcsrc, pcwrite, pcwrite_en,
               instr_done, illegal_op
    );

    modport slave (
        output op, jumpreg, zero, mem_ready,
        input  memread, memwrite, iord, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, zeroext, aluop, pcsrc, pcwrite, pcwrite_en,
               instr_done, illegal_op
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Main control FSM of the multicycle MIPS core. Sequences fetch, decode,
// execute and writeback through the shared ALU, register file, PC and unified
// memory, stalling in FETCH, MEMRD and MEMWR until mem_ready.
// Ports:
//   clk      in   core clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      ctrl master modport (op/jumpreg/zero/mem_ready in, all controls out)
//   state    out  current state number, debug only
module mips_multicycle_ctrl (
    input  logic                          clk,
    input  logic                          reset_n,
    mips_multicycle_ctrl_if.master        bus,
    output logic [3:0]                    state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        IMMEX   = 4'd9,
        IMMWB   = 4'd10,
        JEX     = 4'd11,
        JREX    = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;

    // Controls that depend only on the state (and, for IMMEX, on the opcode,
    // which is stable from DECODE onward because the IR only loads in FETCH).
    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic [3:0] aluop;
        logic [1:0] pcsrc;
        logic       pcjump;   // unconditional PC load in JEX/JREX
        logic       branch;
        logic       done;     // instr_done for states that end unconditionally
    } ctrl_t;

    state_t state_q;
    state_t state_n;
    ctrl_t  ctrl_q;
    logic   running;
    logic   fetch_ok;
    logic   bad_op;
    logic   memwr_done;
    logic   pcwrite_i;

    function automatic logic op_supported(input logic [5:0] opc);
        logic ok;
        case (opc)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI,
            OP_ANDI, OP_ORI, OP_SLTI, OP_J: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] opc);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.memread = 1'b1;
                c.alusrcb = 2'b01;
            end
            DECODE: begin
                c.alusrcb = 2'b11;
            end
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
                c.done     = 1'b1;
            end
            MEMWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 4'b0010;
            end
            RTYPEWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
                c.done     = 1'b1;
            end
            BEQEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 4'b0001;
                c.branch  = 1'b1;
                c.pcsrc   = 2'b01;
                c.done    = 1'b1;
            end
            IMMEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                case (opc)
                    OP_ANDI: begin c.aluop = 4'b0100; c.zeroext = 1'b1; end
                    OP_ORI:  begin c.aluop = 4'b0101; c.zeroext = 1'b1; end
                    OP_SLTI: c.aluop = 4'b0111;
                    default: c.aluop = 4'b0000;
                endcase
            end
            IMMWB: begin
                c.regwrite = 1'b1;
                c.done     = 1'b1;
            end
            JEX: begin
                c.pcjump = 1'b1;
                c.pcsrc  = 2'b10;
                c.done   = 1'b1;
            end
            JREX: begin
                c.pcjump = 1'b1;
                c.pcsrc  = 2'b11;
                c.done   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            FETCH:   if (running && bus.mem_ready) state_n = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW:                      state_n = MEMADR;
                    OP_BEQ:                            state_n = BEQEX;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_n = IMMEX;
                    OP_J:                              state_n = JEX;
                    OP_R:   state_n = bus.jumpreg ? JREX : RTYPEEX;
                    default:                           state_n = FETCH;
                endcase
            end
            MEMADR:  state_n = (bus.op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   if (bus.mem_ready) state_n = MEMWB;
            MEMWB:   state_n = FETCH;
            MEMWR:   if (bus.mem_ready) state_n = FETCH;
            RTYPEEX: state_n = RTYPEWB;
            RTYPEWB: state_n = FETCH;
            BEQEX:   state_n = FETCH;
            IMMEX:   state_n = IMMWB;
            IMMWB:   state_n = FETCH;
            JEX:     state_n = FETCH;
            JREX:    state_n = FETCH;
            default: state_n = FETCH;
        endcase
    end

    // State and state-derived controls are registered together, so the
    // registered controls always describe state_q. 'running' holds the whole
    // controller quiet (memread included) until the first edge after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            ctrl_q  <= '0;
            running <= 1'b0;
        end else begin
            running <= 1'b1;
            state_q <= state_n;
            ctrl_q  <= ctrl_for(state_n, bus.op);
        end
    end

    // Handshake-, opcode- and flag-qualified outputs cannot be registered: they
    // depend on mem_ready, op (valid only from DECODE) and zero in-cycle.
    always_comb begin
        fetch_ok   = running && (state_q == FETCH) && bus.mem_ready;
        bad_op     = (state_q == DECODE) && !op_supported(bus.op);
        memwr_done = (state_q == MEMWR) && bus.mem_ready;
        pcwrite_i  = fetch_ok | ctrl_q.pcjump;

        bus.memread    = ctrl_q.memread;
        bus.memwrite   = ctrl_q.memwrite;
        bus.iord       = ctrl_q.iord;
        bus.irwrite    = fetch_ok;
        bus.regwrite   = ctrl_q.regwrite;
        bus.regdst     = ctrl_q.regdst;
        bus.memtoreg   = ctrl_q.memtoreg;
        bus.alusrca    = ctrl_q.alusrca;
        bus.alusrcb    = ctrl_q.alusrcb;
        bus.zeroext    = ctrl_q.zeroext;
        bus.aluop      = ctrl_q.aluop;
        bus.pcsrc      = ctrl_q.pcsrc;
        bus.pcwrite    = pcwrite_i;
        bus.pcwrite_en = pcwrite_i | (ctrl_q.branch & bus.zero);
        bus.instr_done = ctrl_q.done | bad_op | memwr_done;
        bus.illegal_op = bad_op;
        state          = state_q;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control FSM for the multicycle MIPS core. It decodes the opcode, sequences the shared ALU, register file, PC and unified memory through the fetch, decode, execute and writeback steps, and stalls on a memory ready handshake. It drives the 4-bit `aluop` consumed by the ALU decoder, and takes that decoder's `jumpreg` flag back in to detect `jr`.

## Interface
- No parameters.
- `clk` in 1 — core clock; all state changes on its rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `op` in 6 — instruction[31:26] from the instruction register.
- `jumpreg` in 1 — from the ALU decoder; high when funct=001000 (`jr`).
- `zero` in 1 — ALU zero flag; used only for beq.
- `mem_ready` in 1 — memory completes the current read or write this cycle.
- `memread` out 1 — memory read strobe.
- `memwrite` out 1 — memory write strobe.
- `iord` out 1 — memory address select: 0 = PC, 1 = ALUOut.
- `irwrite` out 1 — instruction register load.
- `regwrite` out 1 — register file write enable.
- `regdst` out 1 — register file write address: 0 = rt, 1 = rd.
- `memtoreg` out 1 — register file write data: 0 = ALUOut, 1 = memory data register.
- `alusrca` out 1 — ALU A operand: 0 = PC, 1 = register A.
- `alusrcb` out 2 — ALU B operand: 00 = B, 01 = 4, 10 = extended immediate, 11 = sign-extended immediate << 2.
- `zeroext` out 1 — immediate is zero-extended (andi, ori).
- `aluop` out 4 — ALU operation: 0000 add, 0001 sub, 0100 and, 0101 or, 0111 slt, 0010 R-type (decode from funct).
- `pcsrc` out 2 — next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A.
- `pcwrite` out 1 — unconditional PC load.
- `pcwrite_en` out 1 — gated PC enable: `pcwrite | (branch & zero)`.
- `instr_done` out 1 — one-cycle pulse on the last cycle of every instruction.
- `illegal_op` out 1 — one-cycle pulse in DECODE when the opcode is unsupported.
- `state` out 4 — current state, for debug.

## Operation
- **Opcodes:** R=000000, lw=100011, sw=101011, beq=000100, addi=001000, andi=001100, ori=001101, slti=001010, j=000010.
- **State encoding:** FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, IMMEX 9, IMMWB 10, JEX 11, JREX 12.
- **Default outputs:** any output not listed for a state is 0.
- **FETCH:** memread=1, iord=0, alusrcb=01, aluop=0000, pcsrc=00.
  - irwrite and pcwrite are asserted only when mem_ready=1; the state then advances to DECODE.
  - Otherwise the state holds in FETCH.
- **DECODE:** alusrcb=11, aluop=0000 (precomputes the branch target). Next state by opcode:
  - lw, sw → MEMADR; beq → BEQEX; addi, andi, ori, slti → IMMEX; j → JEX.
  - R with jumpreg=1 → JREX; R with jumpreg=0 → RTYPEEX.
  - Any other opcode → FETCH, with illegal_op=1 and instr_done=1.
- **MEMADR:** alusrca=1, alusrcb=10, aluop=0000. Next state: lw → MEMRD, sw → MEMWR.
- **MEMRD:** memread=1, iord=1. Holds until mem_ready=1, then → MEMWB.
- **MEMWB:** regwrite=1, memtoreg=1, regdst=0, instr_done=1 → FETCH.
- **MEMWR:** memwrite=1, iord=1. Holds until mem_ready=1, then → FETCH with instr_done=1 in that cycle.
- **RTYPEEX:** alusrca=1, alusrcb=00, aluop=0010 → RTYPEWB.
- **RTYPEWB:** regwrite=1, regdst=1, instr_done=1 → FETCH.
- **BEQEX:** alusrca=1, alusrcb=00, aluop=0001, branch=1, pcsrc=01, instr_done=1 → FETCH.
- **IMMEX:** alusrca=1, alusrcb=10.
  - aluop: addi 0000, andi 0100, ori 0101, slti 0111.
  - zeroext=1 for andi and ori.
  - Next state → IMMWB.
- **IMMWB:** regwrite=1, regdst=0, memtoreg=0, instr_done=1 → FETCH.
- **JEX:** pcwrite=1, pcsrc=10, instr_done=1 → FETCH.
- **JREX:** pcwrite=1, pcsrc=11, instr_done=1 → FETCH.
- **Opcode latching:** `op` is sampled in DECODE and again in MEMADR and IMMEX. The instruction register does not change outside FETCH, so no internal opcode latch is required.
- **Unreachable states 13–15:** behave as FETCH with all strobes 0, then → FETCH.

## Timing
- State register is updated on the rising edge of clk. Outputs are combinational from the state; irwrite, pcwrite and the MEMWR instr_done are additionally gated by mem_ready.
- **Reset:** reset_n low forces state=FETCH immediately. While reset_n is low, every output is 0, including memread and state=0.
- **First fetch:** the first memread occurs in the first clock after reset_n rises.
- **Reset mid-instruction:** abandons the instruction with no writeback and restarts in FETCH.
- **Zero-wait latencies (cycles, FETCH through last state):** lw 5, sw 4, R 4, addi/andi/ori/slti 4, beq 3, j 3, jr 3, illegal 2.
- **Wait states:** each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- **Strobe stability:** memread and memwrite stay continuously high across wait cycles; mem_ready outside those states is ignored.
- **instr_done:** asserted in exactly one cycle per instruction.

## Test plan
- **Reset:** hold reset_n=0 → all outputs 0, state=0. Release with mem_ready=1 → memread=1 next cycle, irwrite=pcwrite=1, state 0→1.
- **lw with 2 wait states in MEMRD:** op=100011 → states 0,1,2,3,3,3,4,0. regwrite=memtoreg=1 only in state 4; instr_done once; 7 cycles total.
- **beq:** op=000100 with zero=1 → pcwrite_en=1 in BEQEX, aluop=0001. With zero=0 → pcwrite_en=0; total 3 cycles.
- **Immediates:** ori and slti → aluop 0101 with zeroext=1, then aluop 0111 with zeroext=0, in IMMEX; IMMWB has regwrite=1, regdst=0.
- **jr and illegal opcode:** R-type with jumpreg=1 → JREX with pcsrc=11, pcwrite=1. op=111111 → illegal_op pulse in DECODE, then FETCH.
- **Reset mid-instruction:** reset_n=0 in MEMWR while memwrite=1 → memwrite drops asynchronously; after release → FETCH, no instr_done.
